riscv_cpu_mc: RTL
=================

# riscv_cpu_mc

Parametrised multi-cycle RV32I/RV32E CPU core for designs with a single shared instruction/data memory that may insert wait states. Each instruction runs through a registered FETCH/DECODE/EXEC/MEM/WB sequence over one valid/ready memory port. It adds a retired-instruction counter and a fault halt, which a single-cycle core with separate instruction and data ports does not have. It replaces the single-cycle core wherever memory is slower than one cycle.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- NREGS, 32: architectural register count, 32 (RV32I) or 16 (RV32E).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle mem_req & mem_ready.
- mem_ready  in  1  memory accepts/completes the transfer this cycle.
- PC  out  32  address of the current instruction.
- retired  out  32  count of retired instructions; wraps 32'hFFFF_FFFF -> 0.
- halted  out  1  core stopped in HALT.
- fault  out  2  halt cause: 0 none, 1 illegal instruction, 2 misaligned data or jump target.

## Operation
- Supported instructions: lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu, lw, sw, addi, slti, sltiu, xori, ori, andi, slli, srli, srai, add, sub, sll, slt, sltu, xor, or, and, srl, sra. All other encodings are illegal.
- When NREGS=16, any rs1, rs2 or rd index of 16 or above is illegal.
- Register x0 reads 0 and writes to it are discarded.
- States and transitions:
  - START -> FETCH.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready, latch IR=mem_rdata and go to DECODE.
  - DECODE: read registers, build the immediate, check legality. Illegal -> HALT with fault=1; otherwise -> EXEC.
  - EXEC: ALU result, branch compare and target calculation.
    - Branches and jumps update PC and retire, then go to FETCH.
    - A jal or jalr target with bits [1:0] != 0 -> HALT with fault=2, with no write and no retire.
    - lw/sw: effective address with bits [1:0] != 0 -> HALT with fault=2. Otherwise -> MEM.
    - ALU, lui and auipc instructions -> WB.
  - MEM: mem_req=1, mem_addr=effective address, mem_we=1 for sw with mem_wdata=rs2.
    - On mem_ready, sw retires and goes to FETCH.
    - On mem_ready, lw latches the read data and goes to WB.
  - WB: write rd, PC+=4, retire, go to FETCH.
  - HALT: absorbing. Only reset exits it.
- jal and jalr write PC+4 to rd in EXEC. jalr clears bit 0 of the target before the alignment check.
- Arithmetic is 32-bit wrap-around. Shift amounts use bits [4:0]. slt is signed and sltu is unsigned.
- A branch not taken sets PC+=4. Retire increments `retired` by 1 on the same edge that updates PC.

## Timing
- Reset values:
  - State START, PC=RESET_PC, retired=0, halted=0, fault=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Register file contents are not reset.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from registered state only; there is no combinational path from mem_ready or mem_rdata.
- While mem_req=1, address, we and wdata stay stable until the cycle with mem_ready. A transfer completes only on an edge where mem_req & mem_ready are both 1.
- mem_ready is ignored while mem_req=0.
- Minimum cycle counts with zero-wait memory (mem_ready tied 1):
  - Branch, jal, jalr: 3 cycles.
  - ALU, lui, auipc, sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle of mem_ready=0 adds exactly 1 cycle.
- Reset asserted mid-transfer aborts it: mem_req drops asynchronously and nothing is written back.
- halted and fault are asserted on the edge that enters HALT. In HALT, mem_req=0.

## Test plan
- Reset with RESET_PC=32'h100 and mem_ready=1: first mem_req in cycle 2 with mem_addr=32'h100, and retired=0 during reset.
- addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sw x3,0(x0) -> word 0 written as 32'h2 with mem_we=1, retired=4 after 16 cycles.
- Stall every request 2 cycles with mem_ready=0: lw completes in 9 cycles, and mem_addr/mem_we stay stable throughout the wait.
- Branch loop: addi x1,x0,3; loop: addi x1,x1,-1; bne x1,x0,loop -> bne taken twice then falls through, retired=7.
- jalr with target 32'h102 -> halted=1, fault=2, rd not written. Separately, encoding 32'h0000_0000 -> fault=1.
- NREGS=16: add x16,x1,x2 -> fault=1. Also assert reset during a stalled MEM phase -> mem_req=0 immediately, and PC=RESET_PC after release.

Source files
------------

// File: rtl/riscv_cpu_mc.sv
// riscv_cpu_mc: multi-cycle RV32I/RV32E core on one shared valid/ready
// memory port, with a retired-instruction counter and a fault halt.
module riscv_cpu_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  fault
);
  localparam logic [2:0] S_START  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam int RW = (NREGS == 16) ? 4 : 5;

  logic [2:0]  state;
  logic [31:0] ir, a, b, imm, res;
  logic [31:0] rf [NREGS];

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_imm, is_reg;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_br    = opc == 7'b1100011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_imm   = opc == 7'b0010011;
  assign is_reg   = opc == 7'b0110011;

  logic ok_op, use_rd, use_rs1, use_rs2, bad_reg, legal;
  always_comb begin
    ok_op   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc, is_jal: begin
        ok_op  = 1'b1;
        use_rd = 1'b1;
      end
      is_jalr, is_ld: begin
        ok_op   = is_jalr ? (f3 == 3'b000) : (f3 == 3'b010);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_br, is_st: begin
        ok_op   = is_br ? (f3[2:1] != 2'b01) : (f3 == 3'b010);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      is_imm: begin
        ok_op = (f3 == 3'b001) ? (f7 == 7'h00) :
                (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) :
                1'b1;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      is_reg: begin
        ok_op = (f7 == 7'h00) ||
                (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // RV32E: only the register fields the format really uses are checked
  assign bad_reg = (NREGS == 16) &&
                   ((use_rd && rd[4]) || (use_rs1 && rs1[4]) ||
                    (use_rs2 && rs2[4]));
  assign legal = ok_op && !bad_reg;

  logic [31:0] rv1, rv2, imm_d;
  assign rv1 = (rs1 == 5'd0) ? 32'd0 : rf[rs1[RW-1:0]];
  assign rv2 = (rs2 == 5'd0) ? 32'd0 : rf[rs2[RW-1:0]];

  always_comb begin
    imm_d = {{20{ir[31]}}, ir[31:20]};
    unique case (1'b1)
      is_st:
        imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      is_br:
        imm_d = {{19{ir[31]}}, ir[31], ir[7],
                 ir[30:25], ir[11:8], 1'b0};
      is_lui, is_auipc:
        imm_d = {ir[31:12], 12'b0};
      is_jal:
        imm_d = {{11{ir[31]}}, ir[31], ir[19:12],
                 ir[20], ir[30:21], 1'b0};
      default: ;
    endcase
  end

  logic [31:0] opb, alu;
  logic [4:0]  sh;
  assign opb = is_reg ? b : imm;
  assign sh  = opb[4:0];

  always_comb begin
    alu = 32'd0;
    unique case (f3)
      3'b000: alu = (is_reg && ir[30]) ? a - opb : a + opb;
      3'b001: alu = a << sh;
      3'b010: alu = {31'b0, $signed(a) < $signed(opb)};
      3'b011: alu = {31'b0, a < opb};
      3'b100: alu = a ^ opb;
      3'b101: alu = ir[30] ? 32'($signed(a) >>> sh) : a >> sh;
      3'b110: alu = a | opb;
      3'b111: alu = a & opb;
      default: ;
    endcase
  end

  logic take;
  always_comb begin
    take = 1'b0;
    unique case (f3)
      3'b000: take = a == b;
      3'b001: take = a != b;
      3'b100: take = $signed(a) < $signed(b);
      3'b101: take = $signed(a) >= $signed(b);
      3'b110: take = a < b;
      3'b111: take = a >= b;
      default: ;
    endcase
  end

  logic [31:0] pc4, br_tgt, j_tgt, ea;
  logic        j_bad, ea_bad;
  assign pc4    = PC + 32'd4;
  assign br_tgt = PC + imm;
  assign ea     = a + imm;
  assign j_tgt  = is_jalr ? (ea & ~32'd1) : br_tgt;
  assign j_bad  = j_tgt[1:0] != 2'b00;
  assign ea_bad = ea[1:0] != 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_START;
      PC      <= RESET_PC;
      retired <= 32'd0;
      halted  <= 1'b0;
      fault   <= 2'd0;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      imm     <= 32'd0;
      res     <= 32'd0;
    end else begin
      unique case (state)
        S_START: state <= S_FETCH;
        S_FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a   <= rv1;
          b   <= rv2;
          imm <= imm_d;
          if (legal) begin
            state <= S_EXEC;
          end else begin
            state  <= S_HALT;
            halted <= 1'b1;
            fault  <= 2'd1;
          end
        end
        S_EXEC: unique case (1'b1)
          is_br: begin
            PC      <= take ? br_tgt : pc4;
            retired <= retired + 32'd1;
            state   <= S_FETCH;
          end
          is_jal, is_jalr: if (j_bad) begin
            state  <= S_HALT;
            halted <= 1'b1;
            fault  <= 2'd2;
          end else begin
            PC      <= j_tgt;
            retired <= retired + 32'd1;
            state   <= S_FETCH;
          end
          is_ld, is_st: if (ea_bad) begin
            state  <= S_HALT;
            halted <= 1'b1;
            fault  <= 2'd2;
          end else begin
            res   <= ea;
            state <= S_MEM;
          end
          default: begin
            res   <= is_lui ? imm : is_auipc ? br_tgt : alu;
            state <= S_WB;
          end
        endcase
        S_MEM: if (mem_ready) begin
          if (is_st) begin
            PC      <= pc4;
            retired <= retired + 32'd1;
            state   <= S_FETCH;
          end else begin
            res   <= mem_rdata;
            state <= S_WB;
          end
        end
        S_WB: begin
          PC      <= pc4;
          retired <= retired + 32'd1;
          state   <= S_FETCH;
        end
        S_HALT: ;
        default: state <= S_HALT;
      endcase
    end
  end

  logic        rf_we;
  logic [31:0] rf_wd;
  assign rf_we = (rd != 5'd0) &&
                 ((state == S_WB) ||
                  (state == S_EXEC && (is_jal || is_jalr) && !j_bad));
  assign rf_wd = (state == S_WB) ? res : pc4;

  always_ff @(posedge clk) begin
    if (rf_we) rf[rd[RW-1:0]] <= rf_wd;
  end

  // bus is a pure decode of registered state
  always_comb begin
    mem_req   = (state == S_FETCH) || (state == S_MEM);
    mem_we    = (state == S_MEM) && is_st;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state == S_FETCH) mem_addr = PC;
    if (state == S_MEM)   mem_addr = res;
    if (mem_we)           mem_wdata = b;
  end
endmodule
